// File: rtl/tx_framer_ctrl.sv
// Transmit framer control: sequences STP/SDP start, payload, END/EDB and
// periodic SKP ordered sets, driving the TX symbol mux select.
module tx_framer_ctrl #(
  parameter logic [7:0] SKP_INTERVAL = 8'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       tx_req,
  input  logic       tx_dllp,
  input  logic [7:0] tx_len,
  input  logic       tx_abort,
  output logic [3:0] control_dk,
  output logic       tx_ack,
  output logic       data_rd,
  output logic       tx_busy
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned SYM_W = 2;

  localparam logic [3:0] DK_DATA = 4'd0;
  localparam logic [3:0] DK_COM  = 4'd1;
  localparam logic [3:0] DK_SKP  = 4'd2;
  localparam logic [3:0] DK_STP  = 4'd3;
  localparam logic [3:0] DK_SDP  = 4'd4;
  localparam logic [3:0] DK_END  = 4'd5;
  localparam logic [3:0] DK_EDB  = 4'd6;
  localparam logic [3:0] DK_IDLE = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKP_COM,
    S_SKP_SYM,
    S_START,
    S_DATA,
    S_END,
    S_EDB
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
  logic               dllp_q, dllp_nxt;
  logic [SYM_W-1:0]   sym_cnt, sym_cnt_nxt;
  logic [CNT_W-1:0]   skp_cnt, skp_cnt_nxt;
  logic               skp_pending, skp_pending_nxt;

  // State and counters advance only on enabled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      byte_cnt    <= '0;
      dllp_q      <= 1'b0;
      sym_cnt     <= '0;
      skp_cnt     <= '0;
      skp_pending <= 1'b0;
    end else if (enb) begin
      state       <= state_nxt;
      byte_cnt    <= byte_cnt_nxt;
      dllp_q      <= dllp_nxt;
      sym_cnt     <= sym_cnt_nxt;
      skp_cnt     <= skp_cnt_nxt;
      skp_pending <= skp_pending_nxt;
    end
  end

  // Next-state logic; byte_cnt holds the latched length, then counts down in DATA
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    dllp_nxt     = dllp_q;
    sym_cnt_nxt  = sym_cnt;
    unique case (state)
      S_IDLE: begin
        if (skp_pending) begin
          state_nxt = S_SKP_COM;
        end else if (tx_req) begin
          state_nxt    = S_START;
          dllp_nxt     = tx_dllp;
          byte_cnt_nxt = tx_len;
        end
      end
      S_SKP_COM: begin
        state_nxt   = S_SKP_SYM;
        sym_cnt_nxt = SYM_W'(2);
      end
      S_SKP_SYM: begin
        if (sym_cnt == '0) state_nxt = S_IDLE;
        else               sym_cnt_nxt = sym_cnt - SYM_W'(1);
      end
      S_START: begin
        if (tx_abort)            state_nxt = S_EDB;
        else if (byte_cnt == '0) state_nxt = S_END;
        else                     state_nxt = S_DATA;
      end
      S_DATA: begin
        byte_cnt_nxt = byte_cnt - CNT_W'(1);
        if (tx_abort)                     state_nxt = S_EDB;
        else if (byte_cnt == CNT_W'(1))   state_nxt = S_END;
      end
      S_END:   state_nxt = S_IDLE;
      S_EDB:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // SKP scheduler: counts idle/packet cycles, request waits for IDLE
  always_comb begin
    skp_cnt_nxt     = skp_cnt;
    skp_pending_nxt = skp_pending;
    if (state == S_IDLE && skp_pending) begin
      skp_pending_nxt = 1'b0;
    end else if (!skp_pending && state != S_SKP_COM && state != S_SKP_SYM) begin
      if (skp_cnt == SKP_INTERVAL - 8'd1) begin
        skp_cnt_nxt     = '0;
        skp_pending_nxt = 1'b1;
      end else begin
        skp_cnt_nxt = skp_cnt + CNT_W'(1);
      end
    end
  end

  // Moore output decode from registered state; strobes gated by enb
  always_comb begin
    control_dk = DK_IDLE;
    unique case (state)
      S_IDLE:    control_dk = DK_IDLE;
      S_SKP_COM: control_dk = DK_COM;
      S_SKP_SYM: control_dk = DK_SKP;
      S_START:   control_dk = dllp_q ? DK_SDP : DK_STP;
      S_DATA:    control_dk = DK_DATA;
      S_END:     control_dk = DK_END;
      S_EDB:     control_dk = DK_EDB;
      default:   control_dk = DK_IDLE;
    endcase
  end

  assign tx_ack  = enb && (state == S_START);
  assign data_rd = enb && (state == S_DATA);
  assign tx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_tx_framer_ctrl.sv
// Directed bench for tx_framer_ctrl with SKP_INTERVAL=8; each scenario
// starts from a fresh reset and checks every cycle's outputs.
module tb_tx_framer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       tx_req;
  logic       tx_dllp;
  logic [7:0] tx_len;
  logic       tx_abort;
  logic [3:0] control_dk;
  logic       tx_ack;
  logic       data_rd;
  logic       tx_busy;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;

  tx_framer_ctrl #(.SKP_INTERVAL(8'd8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .tx_req     (tx_req),
    .tx_dllp    (tx_dllp),
    .tx_len     (tx_len),
    .tx_abort   (tx_abort),
    .control_dk (control_dk),
    .tx_ack     (tx_ack),
    .data_rd    (data_rd),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are applied just after a rising edge; outputs sampled at the falling edge
  task automatic cyc(input string tag, input logic [3:0] dk, input logic ack, input logic rd);
    @(negedge clk);
    check({tag, ".dk"},   32'(control_dk), 32'(dk));
    check({tag, ".ack"},  32'(tx_ack),     32'(ack));
    check({tag, ".rd"},   32'(data_rd),    32'(rd));
    check({tag, ".busy"}, 32'(tx_busy),    32'(dk != 4'd8));
    if (data_rd) rd_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; enb = 1'b1; tx_req = 1'b0; tx_dllp = 1'b0; tx_len = 8'd0; tx_abort = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; enb = 1'b1; tx_req = 1'b0; tx_dllp = 1'b0; tx_len = 8'd0; tx_abort = 1'b0;
    #1;
    check("rst.dk",   32'(control_dk), 32'd8);
    check("rst.ack",  32'(tx_ack),     32'd0);
    check("rst.rd",   32'(data_rd),    32'd0);
    check("rst.busy", 32'(tx_busy),    32'd0);

    // TLP, 3 payload bytes
    do_reset();
    tx_req = 1'b1; tx_dllp = 1'b0; tx_len = 8'd3;
    cyc("tlp3.c0", 4'd8, 1'b0, 1'b0);
    tx_req = 1'b0;
    cyc("tlp3.c1", 4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("tlp3.data", 4'd0, 1'b0, 1'b1);
    cyc("tlp3.end", 4'd5, 1'b0, 1'b0);
    cyc("tlp3.idle", 4'd8, 1'b0, 1'b0);
    check("tlp3.rdcnt", 32'(rd_cnt), 32'd3);

    // DLLP, zero length
    do_reset();
    tx_req = 1'b1; tx_dllp = 1'b1; tx_len = 8'd0;
    cyc("dllp0.c0", 4'd8, 1'b0, 1'b0);
    tx_req = 1'b0;
    cyc("dllp0.sdp", 4'd4, 1'b1, 1'b0);
    cyc("dllp0.end", 4'd5, 1'b0, 1'b0);
    cyc("dllp0.idle", 4'd8, 1'b0, 1'b0);
    check("dllp0.rdcnt", 32'(rd_cnt), 32'd0);

    // Abort in second DATA cycle
    do_reset();
    tx_req = 1'b1; tx_dllp = 1'b0; tx_len = 8'd5;
    cyc("abrt.c0", 4'd8, 1'b0, 1'b0);
    tx_req = 1'b0;
    cyc("abrt.stp", 4'd3, 1'b1, 1'b0);
    cyc("abrt.d0", 4'd0, 1'b0, 1'b1);
    tx_abort = 1'b1;
    cyc("abrt.d1", 4'd0, 1'b0, 1'b1);
    tx_abort = 1'b0;
    cyc("abrt.edb", 4'd6, 1'b0, 1'b0);
    cyc("abrt.idle", 4'd8, 1'b0, 1'b0);
    check("abrt.rdcnt", 32'(rd_cnt), 32'd2);

    // Enable low for two cycles mid-DATA
    do_reset();
    tx_req = 1'b1; tx_dllp = 1'b0; tx_len = 8'd4;
    cyc("enb.c0", 4'd8, 1'b0, 1'b0);
    tx_req = 1'b0;
    cyc("enb.stp", 4'd3, 1'b1, 1'b0);
    cyc("enb.d0", 4'd0, 1'b0, 1'b1);
    cyc("enb.d1", 4'd0, 1'b0, 1'b1);
    enb = 1'b0;
    cyc("enb.frz0", 4'd0, 1'b0, 1'b0);
    cyc("enb.frz1", 4'd0, 1'b0, 1'b0);
    enb = 1'b1;
    cyc("enb.d2", 4'd0, 1'b0, 1'b1);
    cyc("enb.d3", 4'd0, 1'b0, 1'b1);
    cyc("enb.end", 4'd5, 1'b0, 1'b0);
    cyc("enb.idle", 4'd8, 1'b0, 1'b0);
    check("enb.rdcnt", 32'(rd_cnt), 32'd4);

    // tx_req held across END starts the next packet; pending SKP waits for IDLE
    do_reset();
    tx_req = 1'b1; tx_dllp = 1'b0; tx_len = 8'd1;
    cyc("b2b.c0", 4'd8, 1'b0, 1'b0);
    cyc("b2b.stp0", 4'd3, 1'b1, 1'b0);
    cyc("b2b.d0", 4'd0, 1'b0, 1'b1);
    cyc("b2b.end0", 4'd5, 1'b0, 1'b0);
    cyc("b2b.idle", 4'd8, 1'b0, 1'b0);
    tx_req = 1'b0;
    cyc("b2b.stp1", 4'd3, 1'b1, 1'b0);
    cyc("b2b.d1", 4'd0, 1'b0, 1'b1);
    cyc("b2b.end1", 4'd5, 1'b0, 1'b0);
    cyc("b2b.idle1", 4'd8, 1'b0, 1'b0);
    cyc("b2b.com", 4'd1, 1'b0, 1'b0);

    // SKP cadence from reset, then SKP deferred behind a 20-byte packet
    do_reset();
    for (int i = 0; i < 9; i++) cyc("skp.idle", 4'd8, 1'b0, 1'b0);
    cyc("skp.com", 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("skp.sym", 4'd2, 1'b0, 1'b0);
    tx_req = 1'b1; tx_dllp = 1'b0; tx_len = 8'd20;
    cyc("skp.idle2", 4'd8, 1'b0, 1'b0);
    tx_req = 1'b0;
    cyc("skp.stp", 4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc("skp.data", 4'd0, 1'b0, 1'b1);
    cyc("skp.end", 4'd5, 1'b0, 1'b0);
    cyc("skp.idle3", 4'd8, 1'b0, 1'b0);
    cyc("skp.com2", 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("skp.sym2", 4'd2, 1'b0, 1'b0);
    cyc("skp.idle4", 4'd8, 1'b0, 1'b0);
    check("skp.rdcnt", 32'(rd_cnt), 32'd20);

    // Asynchronous reset between edges during DATA
    do_reset();
    tx_req = 1'b1; tx_dllp = 1'b0; tx_len = 8'd5;
    cyc("arst.c0", 4'd8, 1'b0, 1'b0);
    tx_req = 1'b0;
    cyc("arst.stp", 4'd3, 1'b1, 1'b0);
    cyc("arst.d0", 4'd0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.dk",   32'(control_dk), 32'd8);
    check("arst.rd",   32'(data_rd),    32'd0);
    check("arst.busy", 32'(tx_busy),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("arst.idle0", 4'd8, 1'b0, 1'b0);
    cyc("arst.idle1", 4'd8, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
